task2_inv: RTL and testbench

//  Sequential inverse of the sum/product select unit.
//  sel=0: recovers an operand from a sum by subtraction (q = in - b).
//  sel=1: recovers an operand from a product by restoring division, one quotient bit per cycle (q = in / b, r = in % b).

---
 rtl/task2_inv.sv | 145 ++++++++++++++
 tb/tb_task2_inv.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/task2_inv.sv
// Inverse of the sum/product select unit: subtraction (sel=0) or
// restoring division (sel=1, one quotient bit per cycle), with
// valid/ready handshakes on the request and result sides.
module task2_inv #(
  parameter int p_width = 1
) (
  input  logic                 i_w_clk,
  input  logic                 i_w_rst_n,
  input  logic                 i_w_valid,
  output logic                 o_w_ready,
  input  logic [2*p_width:0]   i_w_in,
  input  logic [p_width:0]     i_w_b,
  input  logic                 i_w_sel,
  output logic                 o_w_valid,
  input  logic                 i_w_ready,
  output logic [2*p_width:0]   o_w_q,
  output logic [p_width:0]     o_w_r,
  output logic                 o_w_err
);

  localparam int n_bits = 2*p_width + 1;
  localparam int cnt_w  = $clog2(n_bits);

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_calc = 2'd1;
  localparam logic [1:0] st_done = 2'd2;

  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(n_bits - 1);
  localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(1);

  logic [1:0]         state_r;
  logic [cnt_w-1:0]   cnt_r;
  // Holds the unconsumed dividend bits; quotient bits shift in at the LSB.
  logic [n_bits-1:0]  div_r;
  logic [p_width:0]   rem_r;
  logic [p_width:0]   b_r;
  logic               sel_r;
  logic [n_bits-1:0]  q_r;
  logic [p_width:0]   r_r;
  logic               err_r;
  logic               ready_r;
  logic               valid_r;

  logic [p_width+1:0] trial_s;
  logic [p_width+1:0] diff_s;
  logic               ge_s;
  logic [p_width:0]   rem_next_s;
  logic [n_bits-1:0]  div_next_s;
  logic [n_bits:0]    sub_s;
  logic               b_zero_s;

  // One restoring-division step plus the single-cycle subtraction result.
  always_comb begin
    trial_s    = {rem_r, div_r[n_bits-1]};
    diff_s     = trial_s - {1'b0, b_r};
    ge_s       = (trial_s >= {1'b0, b_r});
    // When the trial is below b it is below 2^(p_width+1), so the top bit is zero.
    if (ge_s) begin
      rem_next_s = diff_s[p_width:0];
    end else begin
      rem_next_s = trial_s[p_width:0];
    end
    div_next_s = {div_r[n_bits-2:0], ge_s};
    // Extra top bit of the difference is the borrow.
    sub_s      = {1'b0, div_r} - {{(p_width+1){1'b0}}, b_r};
    b_zero_s   = (b_r == '0);
  end

  // Control FSM, operand capture, iteration and registered results.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_r <= st_idle;
      cnt_r   <= '0;
      div_r   <= '0;
      rem_r   <= '0;
      b_r     <= '0;
      sel_r   <= 1'b0;
      q_r     <= '0;
      r_r     <= '0;
      err_r   <= 1'b0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        st_idle: begin
          if (i_w_valid) begin
            div_r   <= i_w_in;
            b_r     <= i_w_b;
            sel_r   <= i_w_sel;
            rem_r   <= '0;
            cnt_r   <= cnt_last;
            state_r <= st_calc;
            ready_r <= 1'b0;
          end
        end
        st_calc: begin
          if (!sel_r) begin
            q_r     <= sub_s[n_bits-1:0];
            r_r     <= '0;
            err_r   <= sub_s[n_bits];
            state_r <= st_done;
            valid_r <= 1'b1;
          end else if (b_zero_s) begin
            q_r     <= '1;
            r_r     <= div_r[p_width:0];
            err_r   <= 1'b1;
            state_r <= st_done;
            valid_r <= 1'b1;
          end else begin
            div_r <= div_next_s;
            rem_r <= rem_next_s;
            if (cnt_r == '0) begin
              q_r     <= div_next_s;
              r_r     <= rem_next_s;
              err_r   <= 1'b0;
              state_r <= st_done;
              valid_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r - cnt_one;
            end
          end
        end
        st_done: begin
          if (i_w_ready) begin
            state_r <= st_idle;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r <= st_idle;
          valid_r <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign o_w_ready = ready_r;
  assign o_w_valid = valid_r;
  assign o_w_q     = q_r;
  assign o_w_r     = r_r;
  assign o_w_err   = err_r;

endmodule

// File: tb/tb_task2_inv.sv
// Directed bench for task2_inv: table of vectors at p_width=1, a p_width=3
// instance for the wider division case, plus backpressure and reset sequences.
module tb_task2_inv;

  logic       clk;
  logic       rst_n;

  // p_width = 1 instance
  logic       v1, rdy1, s1, ov1, ordy1, oerr1;
  logic [2:0] in1, oq1;
  logic [1:0] b1, or1;

  // p_width = 3 instance
  logic       v3, rdy3, s3, ov3, ordy3, oerr3;
  logic [6:0] in3, oq3;
  logic [3:0] b3, or3;

  int n_applied = 0;
  int n_miss    = 0;

  task2_inv #(.p_width(1)) dut1 (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_valid(v1), .o_w_ready(ordy1),
    .i_w_in(in1), .i_w_b(b1), .i_w_sel(s1), .o_w_valid(ov1), .i_w_ready(rdy1),
    .o_w_q(oq1), .o_w_r(or1), .o_w_err(oerr1)
  );

  task2_inv #(.p_width(3)) dut3 (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_valid(v3), .o_w_ready(ordy3),
    .i_w_in(in3), .i_w_b(b3), .i_w_sel(s3), .o_w_valid(ov3), .i_w_ready(rdy3),
    .o_w_q(oq3), .o_w_r(or3), .o_w_err(oerr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic [2:0] in;
    logic [1:0] b;
    logic [2:0] q;
    logic [1:0] r;
    logic       err;
    int         lat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issue one request to dut1 and count edges until the result is valid.
  task automatic run1(input logic sel, input logic [2:0] in, input logic [1:0] b, output int lat);
    @(negedge clk);
    chk("ready_before_issue", 32'(ordy1), 32'd1);
    v1 = 1'b1; in1 = in; b1 = b; s1 = sel; rdy1 = 1'b0;
    @(posedge clk); #1;
    v1 = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ov1) break;
    end
    if (!ov1) chk("valid_timeout", 32'(ov1), 32'd1);
  endtask

  task automatic release1();
    @(negedge clk);
    rdy1 = 1'b1;
    @(posedge clk); #1;
    rdy1 = 1'b0;
    chk("valid_after_accept", 32'(ov1), 32'd0);
    chk("ready_after_accept", 32'(ordy1), 32'd1);
  endtask

  task automatic run3(input logic sel, input logic [6:0] in, input logic [3:0] b,
                      input logic [6:0] eq, input logic [3:0] er, input logic ee, input int elat);
    int lat;
    @(negedge clk);
    v3 = 1'b1; in3 = in; b3 = b; s3 = sel; rdy3 = 1'b0;
    @(posedge clk); #1;
    v3 = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ov3) break;
    end
    chk("w3_valid", 32'(ov3), 32'd1);
    chk("w3_latency", 32'(lat), 32'(elat));
    chk("w3_q", 32'(oq3), 32'(eq));
    chk("w3_r", 32'(or3), 32'(er));
    chk("w3_err", 32'(oerr3), 32'(ee));
    @(negedge clk);
    rdy3 = 1'b1;
    @(posedge clk); #1;
    rdy3 = 1'b0;
    chk("w3_idle", 32'(ordy3), 32'd1);
  endtask

  initial begin
    int lat;
    tbl[0]  = '{1'b1, 3'd6, 2'd2, 3'd3, 2'd0, 1'b0, 3};
    tbl[1]  = '{1'b1, 3'd7, 2'd3, 3'd2, 2'd1, 1'b0, 3};
    tbl[2]  = '{1'b1, 3'd5, 2'd0, 3'd7, 2'd1, 1'b1, 1};
    tbl[3]  = '{1'b0, 3'd5, 2'd3, 3'd2, 2'd0, 1'b0, 1};
    tbl[4]  = '{1'b0, 3'd1, 2'd3, 3'd6, 2'd0, 1'b1, 1};
    tbl[5]  = '{1'b1, 3'd7, 2'd1, 3'd7, 2'd0, 1'b0, 3};
    tbl[6]  = '{1'b1, 3'd2, 2'd3, 3'd0, 2'd2, 1'b0, 3};
    tbl[7]  = '{1'b0, 3'd7, 2'd0, 3'd7, 2'd0, 1'b0, 1};
    tbl[8]  = '{1'b0, 3'd3, 2'd3, 3'd0, 2'd0, 1'b0, 1};
    tbl[9]  = '{1'b1, 3'd0, 2'd2, 3'd0, 2'd0, 1'b0, 3};
    tbl[10] = '{1'b1, 3'd4, 2'd0, 3'd7, 2'd0, 1'b1, 1};

    rst_n = 1'b0;
    v1 = 1'b0; rdy1 = 1'b0; s1 = 1'b0; in1 = 3'd0; b1 = 2'd0;
    v3 = 1'b0; rdy3 = 1'b0; s3 = 1'b0; in3 = 7'd0; b3 = 4'd0;
    #12;
    chk("rst_ready", 32'(ordy1), 32'd1);
    chk("rst_valid", 32'(ov1), 32'd0);
    chk("rst_q", 32'(oq1), 32'd0);
    chk("rst_r", 32'(or1), 32'd0);
    chk("rst_err", 32'(oerr1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      run1(tbl[i].sel, tbl[i].in, tbl[i].b, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("v%0d_q", i), 32'(oq1), 32'(tbl[i].q));
      chk($sformatf("v%0d_r", i), 32'(or1), 32'(tbl[i].r));
      chk($sformatf("v%0d_err", i), 32'(oerr1), 32'(tbl[i].err));
      chk($sformatf("v%0d_ready_in_done", i), 32'(ordy1), 32'd0);
      release1();
    end

    // Backpressure: result held for 5 cycles, a new request meanwhile is ignored
    run1(1'b0, 3'd5, 2'd3, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v1 = 1'b1; in1 = 3'd7; b1 = 2'd1; s1 = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid", 32'(ov1), 32'd1);
      chk("bp_ready", 32'(ordy1), 32'd0);
      chk("bp_q", 32'(oq1), 32'd2);
      chk("bp_r", 32'(or1), 32'd0);
      chk("bp_err", 32'(oerr1), 32'd0);
    end
    @(negedge clk);
    v1 = 1'b0; rdy1 = 1'b1;
    @(posedge clk); #1;
    rdy1 = 1'b0;
    chk("bp_release_valid", 32'(ov1), 32'd0);
    chk("bp_release_ready", 32'(ordy1), 32'd1);
    @(posedge clk); #1;
    chk("bp_no_stray_start", 32'(ordy1), 32'd1);
    chk("bp_q_held_idle", 32'(oq1), 32'd2);

    // Leave a nonzero result (q=2, r=1) so the reset clear is visible
    run1(1'b1, 3'd7, 2'd3, lat);
    release1();

    // Reset after two division cycles
    @(negedge clk);
    v1 = 1'b1; in1 = 3'd7; b1 = 2'd3; s1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(ov1), 32'd0);
    chk("abort_ready", 32'(ordy1), 32'd1);
    chk("abort_q", 32'(oq1), 32'd0);
    chk("abort_r", 32'(or1), 32'd0);
    chk("abort_err", 32'(oerr1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run1(1'b1, 3'd6, 2'd3, lat);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_q", 32'(oq1), 32'd2);
    chk("post_rst_r", 32'(or1), 32'd0);
    chk("post_rst_err", 32'(oerr1), 32'd0);
    release1();

    // Wider instance: N = 7
    run3(1'b1, 7'd100, 4'd7, 7'd14, 4'd2, 1'b0, 7);
    run3(1'b1, 7'd100, 4'd0, 7'd127, 4'd4, 1'b1, 1);
    run3(1'b0, 7'd3, 4'd10, 7'd121, 4'd0, 1'b1, 1);
    run3(1'b1, 7'd127, 4'd15, 7'd8, 4'd7, 1'b0, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
